// File: rtl/servo_switch_sequencer_pkg.sv
// Shared types and constants for the servo switch sequencer and its PWM source.
package servo_switch_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    PRESS  = 3'd2,
    RETURN = 3'd3,
    FAULT  = 3'd4
  } seq_state_t;

  // Index into pwm_in: which wave is forwarded to the servo
  localparam logic SEL_REST = 1'b0;
  localparam logic SEL_FLIP = 1'b1;

  // Frame length of the upstream PWM generator in clock cycles (20 ms at 50 kHz)
  localparam int FRAME_CYCLES = 1000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/servo_switch_sequencer_req_debouncer.sv
// Level debouncer for the synchronised request: the output follows the input
// only after the input has disagreed with it for CYCLES consecutive samples.
module req_debouncer
  import servo_switch_sequencer_pkg::*;
#(
  parameter int CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  // Count consecutive disagreeing samples; any agreeing sample restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CW'(CYCLES - 1)) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/servo_switch_sequencer.sv
// Servo switch sequencer: forwards one of two 50 Hz PWM waves to the servo pin,
// switching only at frame boundaries, and runs a flip/return sequence on request.
// Optional request debouncing is enabled by defining SERVO_DEBOUNCE_EN.
module servo_switch_sequencer
  import servo_switch_sequencer_pkg::*;
#(
  parameter int PRESS_FRAMES    = 25,
  parameter int RETURN_FRAMES   = 25,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int FRAME_TIMEOUT   = 2047
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] pwm_in,
  input  logic       req,
  output logic       servo_out,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  localparam int FW = $clog2(max_int(PRESS_FRAMES, RETURN_FRAMES) + 1);
  localparam int WW = $clog2(FRAME_TIMEOUT + 1);

  if (PRESS_FRAMES < 1 || RETURN_FRAMES < 1 || DEBOUNCE_CYCLES < 1 || FRAME_TIMEOUT < 2) begin : g_param_check
    $error("servo_switch_sequencer: parameter out of range");
  end

  logic [1:0]    pwm_meta, pwm_sync;
  logic [1:0]    sync_vld;
  logic          pwm0_prev;
  logic          req_meta, req_sync;
  logic          req_level, req_prev, req_rise;
  logic          frame_start;
  logic [WW-1:0] wdog_cnt;
  logic          wdog_expired;
  seq_state_t    state, state_next;
  logic          sel, sel_next;
  logic [FW-1:0] fcnt, fcnt_next;
  logic          fwd_en;

  // Two-flop synchronisers; the edge-detect history is held high until the
  // chain carries real samples so a reset released mid-pulse is not a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_meta  <= 2'b00;
      pwm_sync  <= 2'b00;
      req_meta  <= 1'b0;
      req_sync  <= 1'b0;
      sync_vld  <= 2'b00;
      pwm0_prev <= 1'b1;
    end else begin
      pwm_meta  <= pwm_in;
      pwm_sync  <= pwm_meta;
      req_meta  <= req;
      req_sync  <= req_meta;
      sync_vld  <= {sync_vld[0], 1'b1};
      pwm0_prev <= sync_vld[1] ? pwm_sync[0] : 1'b1;
    end
  end

  assign frame_start = pwm_sync[0] & ~pwm0_prev;

`ifdef SERVO_DEBOUNCE_EN
  req_debouncer #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_req_debouncer (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (req_sync),
    .dout (req_level)
  );
`else
  assign req_level = req_sync;
`endif

  assign req_rise = req_level & ~req_prev;

  // Frame watchdog: cleared by each frame start, saturates at the timeout value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
    end else if (frame_start) begin
      wdog_cnt <= '0;
    end else if (!wdog_expired) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  assign wdog_expired = (wdog_cnt == WW'(FRAME_TIMEOUT));

  // Sequencer next-state logic; watchdog expiry overrides every other transition
  always_comb begin
    state_next = state;
    sel_next   = sel;
    fcnt_next  = fcnt;
    done       = 1'b0;
    if (wdog_expired) begin
      state_next = FAULT;
      sel_next   = SEL_REST;
    end else begin
      case (state)
        IDLE: begin
          if (req_rise) state_next = ARM;
        end
        ARM: begin
          if (frame_start) begin
            sel_next   = SEL_FLIP;
            fcnt_next  = FW'(1);
            state_next = PRESS;
          end
        end
        PRESS: begin
          if (frame_start) begin
            if (fcnt == FW'(PRESS_FRAMES)) begin
              sel_next   = SEL_REST;
              fcnt_next  = FW'(1);
              state_next = RETURN;
            end else begin
              fcnt_next = fcnt + 1'b1;
            end
          end
        end
        RETURN: begin
          if (frame_start) begin
            if (fcnt == FW'(RETURN_FRAMES)) begin
              fcnt_next  = '0;
              done       = 1'b1;
              state_next = IDLE;
            end else begin
              fcnt_next = fcnt + 1'b1;
            end
          end
        end
        FAULT: begin
          sel_next = SEL_REST;
        end
        default: begin
          state_next = IDLE;
          sel_next   = SEL_REST;
          fcnt_next  = '0;
        end
      endcase
    end
  end

  // State, wave select and output register; the pin stays low until the first
  // whole frame after reset and is forced low as soon as the fault is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= SEL_REST;
      fcnt      <= '0;
      req_prev  <= 1'b0;
      fwd_en    <= 1'b0;
      servo_out <= 1'b0;
    end else begin
      state     <= state_next;
      sel       <= sel_next;
      fcnt      <= fcnt_next;
      req_prev  <= req_level;
      if (frame_start) fwd_en <= 1'b1;
      servo_out <= (state_next != FAULT) && (fwd_en || frame_start) && pwm_sync[sel];
    end
  end

  assign busy  = ((state == ARM) || (state == PRESS) || (state == RETURN)) && !done;
  assign fault = (state == FAULT);

endmodule

// File: tb/tb_servo_switch_sequencer.sv
// Self-checking bench for servo_switch_sequencer: table of per-frame vectors,
// hand-written reset/watchdog/glitch sequences and a randomized frame-level model.
module tb_servo_switch_sequencer;
  import servo_switch_sequencer_pkg::*;

  localparam int P_FRAMES = 3;
  localparam int R_FRAMES = 2;
  localparam int DEB      = 50;
  localparam int TIMEOUT  = 2047;
  localparam int W_REST   = 27;
  localparam int W_FLIP   = 57;
`ifdef SERVO_DEBOUNCE_EN
  localparam int GLITCH_STARTS = 0;
`else
  localparam int GLITCH_STARTS = 1;
`endif

  typedef struct {
    int req_len;
    int exp_width;
    int exp_done;
    int exp_busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] pwm_in;
  logic       req;
  logic       servo_out, busy, done, fault;

  int     n_checks = 0;
  int     n_fail   = 0;
  bit     gen_run;
  longint cyc = 0;
  longint req_rise_at = -1;
  longint req_fall_at = -1;
  int     acc_width, acc_done, tot_done;
  logic   last_busy, last_fault, last_servo;
  vec_t   vecs[25];
  int     left, had, exp_w, exp_d, rph, rlen;
  bit     do_req;

  servo_switch_sequencer #(
    .PRESS_FRAMES   (P_FRAMES),
    .RETURN_FRAMES  (R_FRAMES),
    .DEBOUNCE_CYCLES(DEB),
    .FRAME_TIMEOUT  (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwm_in   (pwm_in),
    .req      (req),
    .servo_out(servo_out),
    .busy     (busy),
    .done     (done),
    .fault    (fault)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One cycle: sample outputs at the falling edge, then drive the next inputs
  task automatic tick(input int ph);
    @(negedge clk);
    if (servo_out === 1'b1) acc_width++;
    if (done === 1'b1) acc_done++;
    last_busy  = busy;
    last_fault = fault;
    last_servo = servo_out;
    if (ph >= 0 && gen_run) pwm_in = {(ph < W_FLIP), (ph < W_REST)};
    else pwm_in = 2'b00;
    if (cyc == req_rise_at) req = 1'b1;
    if (cyc == req_fall_at) req = 1'b0;
    cyc++;
  endtask

  task automatic applyStimulus(input int first_ph, input int n);
    acc_width = 0;
    acc_done  = 0;
    for (int i = 0; i < n; i++) tick((first_ph < 0) ? -1 : (first_ph + i) % FRAME_CYCLES);
  endtask

  task automatic schedReq(input int delay, input int len);
    req_rise_at = cyc + delay;
    req_fall_at = cyc + delay + len;
  endtask

  task automatic runFrame(input int req_ph, input int req_len);
    if (req_len > 0) schedReq(req_ph, req_len);
    applyStimulus(0, FRAME_CYCLES);
  endtask

  initial begin
    #1900000;
    $display("[TB] FAIL global timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{0,    W_REST, 0, 0};
    vecs[1]  = '{100,  W_REST, 0, 1};
    vecs[2]  = '{0,    W_FLIP, 0, 1};
    vecs[3]  = '{100,  W_FLIP, 0, 1};
    vecs[4]  = '{0,    W_FLIP, 0, 1};
    vecs[5]  = '{0,    W_REST, 0, 1};
    vecs[6]  = '{0,    W_REST, 0, 1};
    vecs[7]  = '{0,    W_REST, 1, 0};
    vecs[8]  = '{0,    W_REST, 0, 0};
    vecs[9]  = '{8000, W_REST, 0, 1};
    vecs[10] = '{0,    W_FLIP, 0, 1};
    vecs[11] = '{0,    W_FLIP, 0, 1};
    vecs[12] = '{0,    W_FLIP, 0, 1};
    vecs[13] = '{0,    W_REST, 0, 1};
    vecs[14] = '{0,    W_REST, 0, 1};
    vecs[15] = '{0,    W_REST, 1, 0};
    vecs[16] = '{0,    W_REST, 0, 0};
    vecs[17] = '{0,    W_REST, 0, 0};
    vecs[18] = '{100,  W_REST, 0, 1};
    vecs[19] = '{0,    W_FLIP, 0, 1};
    vecs[20] = '{0,    W_FLIP, 0, 1};
    vecs[21] = '{0,    W_FLIP, 0, 1};
    vecs[22] = '{0,    W_REST, 0, 1};
    vecs[23] = '{0,    W_REST, 0, 1};
    vecs[24] = '{0,    W_REST, 1, 0};

    rst_n   = 1'b0;
    pwm_in  = 2'b00;
    req     = 1'b0;
    gen_run = 1'b1;
    applyStimulus(-1, 3);
    checkOutput("reset servo_out", last_servo, 0);
    checkOutput("reset busy", last_busy, 0);
    checkOutput("reset fault", last_fault, 0);
    checkOutput("reset done", done, 0);
    rst_n = 1'b1;
    applyStimulus(-1, 5);

    $display("[TB] table vectors");
    for (int i = 0; i < 25; i++) begin
      runFrame(100, vecs[i].req_len);
      checkOutput($sformatf("row%0d width", i), acc_width, vecs[i].exp_width);
      checkOutput($sformatf("row%0d done", i), acc_done, vecs[i].exp_done);
      checkOutput($sformatf("row%0d busy", i), last_busy, vecs[i].exp_busy);
      checkOutput($sformatf("row%0d fault", i), last_fault, 0);
    end

    $display("[TB] short request glitch");
    runFrame(100, 20);
    checkOutput("glitch busy", last_busy, GLITCH_STARTS);
    tot_done = 0;
    for (int i = 0; i < P_FRAMES + R_FRAMES + 1; i++) begin
      runFrame(0, 0);
      tot_done += acc_done;
    end
    checkOutput("glitch done count", tot_done, GLITCH_STARTS);
    checkOutput("glitch idle after", last_busy, 0);

    $display("[TB] randomized requests against frame model");
    left = 0;
    for (int f = 0; f < 25; f++) begin
      had = left;
      if (left > 0) left--;
      exp_d  = (had > 0 && left == 0) ? 1 : 0;
      exp_w  = (left > R_FRAMES) ? W_FLIP : W_REST;
      do_req = ($urandom_range(0, 2) == 0);
      rph    = $urandom_range(100, 700);
      rlen   = $urandom_range(60, 200);
      runFrame(rph, do_req ? rlen : 0);
      if (do_req && left == 0) left = P_FRAMES + R_FRAMES + 1;
      checkOutput($sformatf("rand%0d width", f), acc_width, exp_w);
      checkOutput($sformatf("rand%0d done", f), acc_done, exp_d);
      checkOutput($sformatf("rand%0d busy", f), last_busy, (left > 0) ? 1 : 0);
      checkOutput($sformatf("rand%0d fault", f), last_fault, 0);
    end
    for (int i = 0; i < P_FRAMES + R_FRAMES + 1; i++) runFrame(0, 0);

    $display("[TB] reset during flip");
    runFrame(100, 100);
    runFrame(0, 0);
    checkOutput("first flip width", acc_width, W_FLIP);
    applyStimulus(0, 40);
    checkOutput("pre-reset servo high", last_servo, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset servo_out", servo_out, 0);
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset done", done, 0);
    checkOutput("async reset fault", fault, 0);
    applyStimulus(40, 5);
    rst_n = 1'b1;
    applyStimulus(45, FRAME_CYCLES - 45);
    checkOutput("partial frame after reset", acc_width, 0);
    runFrame(0, 0);
    checkOutput("rest after reset width", acc_width, W_REST);
    checkOutput("rest after reset busy", last_busy, 0);

    $display("[TB] generator stall");
    runFrame(100, 100);
    runFrame(0, 0);
    gen_run = 1'b0;
    applyStimulus(-1, 1040);
    checkOutput("no fault before timeout", last_fault, 0);
    checkOutput("busy before timeout", last_busy, 1);
    applyStimulus(-1, 60);
    checkOutput("fault after timeout", last_fault, 1);
    checkOutput("busy in fault", last_busy, 0);
    checkOutput("servo low in fault", last_servo, 0);
    gen_run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      runFrame(0, 0);
      checkOutput($sformatf("fault resumed%0d width", i), acc_width, 0);
      checkOutput($sformatf("fault resumed%0d sticky", i), last_fault, 1);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("fault cleared by reset", fault, 0);
    applyStimulus(-1, 3);
    rst_n = 1'b1;
    applyStimulus(-1, 5);
    runFrame(0, 0);
    checkOutput("recovered width", acc_width, W_REST);
    checkOutput("recovered fault", last_fault, 0);
    checkOutput("recovered busy", last_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
